// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges ALU and load writeback into one register-file write port, with bypass and a stall counter
module rf_write_arbiter #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32,
  parameter int CNT_LEN     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [RF_ADDR_LEN-1:0] alu_rd_addr,
  input  logic [RF_DATA_LEN-1:0] alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [RF_ADDR_LEN-1:0] mem_rd_addr,
  input  logic [RF_DATA_LEN-1:0] mem_data,
  output logic                   w_en,
  output logic [RF_ADDR_LEN-1:0] rd_addr,
  output logic [RF_DATA_LEN-1:0] rd_write_data,
  input  logic [RF_ADDR_LEN-1:0] rs1_addr,
  input  logic [RF_ADDR_LEN-1:0] rs2_addr,
  input  logic [RF_DATA_LEN-1:0] rf_rs1_data,
  input  logic [RF_DATA_LEN-1:0] rf_rs2_data,
  output logic [RF_DATA_LEN-1:0] fwd_rs1_data,
  output logic [RF_DATA_LEN-1:0] fwd_rs2_data,
  input  logic                   perf_clr,
  output logic [CNT_LEN-1:0]     stall_cnt
);
  logic alu_claim, mem_claim;
  always_comb begin
    alu_claim = alu_valid && (alu_rd_addr != '0);
    mem_claim = mem_valid && (mem_rd_addr != '0);
    // loads to x0 are swallowed even while the ALU owns the port
    mem_ready = rst && (!alu_claim || mem_rd_addr == '0);
    fwd_rs1_data = (w_en && rs1_addr == rd_addr && rs1_addr != '0) ? rd_write_data : rf_rs1_data;
    fwd_rs2_data = (w_en && rs2_addr == rd_addr && rs2_addr != '0) ? rd_write_data : rf_rs2_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_en          <= 1'b0;
      rd_addr       <= '0;
      rd_write_data <= '0;
    end else if (alu_claim) begin
      w_en          <= 1'b1;
      rd_addr       <= alu_rd_addr;
      rd_write_data <= alu_data;
    end else if (mem_claim) begin
      w_en          <= 1'b1;
      rd_addr       <= mem_rd_addr;
      rd_write_data <= mem_data;
    end else begin
      w_en          <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst || perf_clr)
      stall_cnt <= '0;
    else if (mem_valid && !mem_ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
